csi_tx_packetizer: RTL and testbench

CSI_TX_PACKETIZER -- requirements
Module: csi_tx_packetizer

---
 rtl/csi_tx_packetizer.sv | 184 ++++++++++++++++++
 tb/tb_csi_tx_packetizer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_tx_packetizer.sv
// CSI-2 TX packetizer: turns packet commands plus a payload stream into 2-lane HS byte words
// (sync, header, payload, CRC), then holds tx_hs_req low for GAP_CYCLES before the next burst.
// Latency: a command accepted at edge N shows the sync word in cycle N+1; a payload word accepted
// at edge M shows in cycle M+1. Backpressure: cmd_ready only in IDLE with enable; pay_ready only
// while payload words remain, and a missing pay_valid inserts an idle lane cycle (sticky underrun).
//
// Ports:
//   clk_i, reset_i            byte clock, synchronous active-high reset
//   enable_i                  gates acceptance of new commands only
//   cmd_*                     packet command (long/short, VC, DT, WC or short data field)
//   pay_*                     16-bit payload stream, byte0 = bits[7:0]
//   tx_hs_req_o/tx_data_o/tx_valid_o  registered lane outputs, lane0 = bits[7:0]
//   err_underrun_o/err_odd_wc_o       sticky error flags, cleared by reset only
module csi_tx_packetizer #(
  parameter int GAP_CYCLES = 16,
  parameter int NUM_LANE   = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    enable_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_long_i,
  input  logic [1:0]              cmd_vc_i,
  input  logic [5:0]              cmd_dt_i,
  input  logic [15:0]             cmd_wc_i,
  input  logic [8*NUM_LANE-1:0]   pay_data_i,
  input  logic                    pay_valid_i,
  output logic                    pay_ready_o,
  output logic                    tx_hs_req_o,
  output logic [8*NUM_LANE-1:0]   tx_data_o,
  output logic                    tx_valid_o,
  output logic                    err_underrun_o,
  output logic                    err_odd_wc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_HDR0,
    S_HDR1,
    S_PAYLOAD,
    S_CRC,
    S_GAP
  } state_t;

  localparam logic [15:0] SYNC_WORD = 16'hB8B8;
  localparam logic [7:0]  GAP_LOAD  = 8'(GAP_CYCLES - 1);

  state_t      state_q;
  logic        long_q;
  logic [7:0]  di_q;
  logic [15:0] wc_q;
  logic [14:0] words_q;     // payload words not yet accepted; 15 bits covers WC=0xFFFE exactly
  logic [15:0] crc_q;
  logic [7:0]  gap_q;
  logic        tx_hs_q;
  logic        tx_valid_q;
  logic [15:0] tx_data_q;
  logic        err_underrun_q;
  logic        err_odd_wc_q;

  logic [15:0] wc_eff_d;
  logic [15:0] crc_d;
  logic [5:0]  ecc_d;

  // CRC-16/0x8408, LSB-first: bits 0..7 are byte0, bits 8..15 byte1, so a plain
  // bit loop over the word processes the bytes in lane order.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 16; i++) begin
      if (c[0] ^ w[i]) c = (c >> 1) ^ 16'h8408;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // CSI-2 header Hamming code; each mask selects the data bits feeding one parity bit.
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    return {^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
            ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
  endfunction

  always_comb begin
    wc_eff_d = cmd_wc_i;
    // Long packets carry whole 16-bit words only, so an odd byte count is rounded down.
    if (cmd_long_i) wc_eff_d[0] = 1'b0;
    crc_d = crc16_word(crc_q, pay_data_i);
    ecc_d = ecc6({wc_q, di_q});
  end

  assign cmd_ready_o = (state_q == S_IDLE) && enable_i && !reset_i;

  // Ready is already raised while HDR1 is on the lanes so the first payload word
  // follows the header without a dead cycle.
  assign pay_ready_o = !reset_i && (words_q != '0) &&
                       ((state_q == S_HDR1) || (state_q == S_PAYLOAD));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      long_q         <= 1'b0;
      di_q           <= '0;
      wc_q           <= '0;
      words_q        <= '0;
      crc_q          <= '0;
      gap_q          <= '0;
      tx_hs_q        <= 1'b0;
      tx_valid_q     <= 1'b0;
      tx_data_q      <= '0;
      err_underrun_q <= 1'b0;
      err_odd_wc_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            state_q    <= S_SYNC;
            long_q     <= cmd_long_i;
            di_q       <= {cmd_vc_i, cmd_dt_i};
            wc_q       <= wc_eff_d;
            words_q    <= cmd_long_i ? wc_eff_d[15:1] : '0;
            crc_q      <= 16'hFFFF;
            tx_hs_q    <= 1'b1;
            tx_valid_q <= 1'b1;
            tx_data_q  <= SYNC_WORD;
            if (cmd_long_i && cmd_wc_i[0]) err_odd_wc_q <= 1'b1;
          end
        end
        S_SYNC: begin
          state_q   <= S_HDR0;
          tx_data_q <= {wc_q[7:0], di_q};
        end
        S_HDR0: begin
          state_q   <= S_HDR1;
          tx_data_q <= {2'b00, ecc_d, wc_q[15:8]};
        end
        S_HDR1, S_PAYLOAD: begin
          if (state_q == S_HDR1 && !long_q) begin
            state_q    <= S_GAP;
            gap_q      <= GAP_LOAD;
            tx_hs_q    <= 1'b0;
            tx_valid_q <= 1'b0;
          end else if (words_q == '0) begin
            // All payload on the lanes (or none at all): the running CRC is final.
            state_q    <= S_CRC;
            tx_valid_q <= 1'b1;
            tx_data_q  <= crc_q;
          end else begin
            state_q <= S_PAYLOAD;
            if (pay_valid_i) begin
              tx_valid_q <= 1'b1;
              tx_data_q  <= pay_data_i;
              words_q    <= words_q - 15'd1;
              crc_q      <= crc_d;
            end else begin
              // Starved: keep the HS burst open with an invalid lane cycle.
              tx_valid_q     <= 1'b0;
              err_underrun_q <= 1'b1;
            end
          end
        end
        S_CRC: begin
          state_q    <= S_GAP;
          gap_q      <= GAP_LOAD;
          tx_hs_q    <= 1'b0;
          tx_valid_q <= 1'b0;
        end
        S_GAP: begin
          if (gap_q == '0) state_q <= S_IDLE;
          else             gap_q   <= gap_q - 8'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_hs_req_o    = tx_hs_q;
  assign tx_valid_o     = tx_valid_q;
  assign tx_data_o      = tx_data_q;
  assign err_underrun_o = err_underrun_q;
  assign err_odd_wc_o   = err_odd_wc_q;

endmodule

// File: tb/tb_csi_tx_packetizer.sv
// Testbench for csi_tx_packetizer: packet driver feeding an expected-word scoreboard,
// with an independent lane monitor comparing every valid word, burst gaps and idle cycles.
// Checks use a table-driven CRC and a syndrome-table ECC reference.
module tb_csi_tx_packetizer;

  localparam int GAP = 16;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        enable_i = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_long_i = 1'b0;
  logic [1:0]  cmd_vc_i = '0;
  logic [5:0]  cmd_dt_i = '0;
  logic [15:0] cmd_wc_i = '0;
  logic [15:0] pay_data_i = '0;
  logic        pay_valid_i = 1'b0;
  logic        pay_ready_o;
  logic        tx_hs_req_o;
  logic [15:0] tx_data_o;
  logic        tx_valid_o;
  logic        err_underrun_o;
  logic        err_odd_wc_o;

  always #5 clk_i = ~clk_i;

  csi_tx_packetizer #(.GAP_CYCLES(GAP), .NUM_LANE(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_long_i(cmd_long_i),
    .cmd_vc_i(cmd_vc_i), .cmd_dt_i(cmd_dt_i), .cmd_wc_i(cmd_wc_i),
    .pay_data_i(pay_data_i), .pay_valid_i(pay_valid_i), .pay_ready_o(pay_ready_o),
    .tx_hs_req_o(tx_hs_req_o), .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o),
    .err_underrun_o(err_underrun_o), .err_odd_wc_o(err_odd_wc_o)
  );

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  int          exp_bub[$];
  bit          und_m = 1'b0;
  bit          odd_m = 1'b0;
  logic [15:0] crc_tbl [256];

  localparam logic [5:0] SYND [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23, 6'h25,
    6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  logic [7:0] fixed_bytes [24] = '{
    8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
    8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ecc_model(input logic [23:0] d);
    logic [5:0] e;
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= SYND[i];
    return {2'b00, e};
  endfunction

  function automatic logic [15:0] crc_of(input logic [7:0] b[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (b[i]) c = (c >> 8) ^ crc_tbl[c[7:0] ^ b[i]];
    return c;
  endfunction

  // Monitor: compares every valid lane word, counts invalid cycles inside each
  // burst and the length of the hs_req-low gap between bursts.
  bit in_burst = 1'b0;
  bit have_prev = 1'b0;
  int low_run = 0;
  int bubbles = 0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      in_burst = 1'b0;
      have_prev = 1'b0;
      low_run = 0;
    end else begin
      if (tx_valid_o) begin
        n_chk++;
        if (!tx_hs_req_o) begin
          n_fail++;
          $display("FAIL valid_without_hs: tx_valid=1 while tx_hs_req=0");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %h, no word expected", tx_data_o);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (tx_data_o !== e) begin
            n_fail++;
            $display("FAIL tx_word: got %h expected %h", tx_data_o, e);
          end
        end
      end
      if (tx_hs_req_o) begin
        if (!in_burst) begin
          if (have_prev) chk("hs_gap_min", 32'(low_run >= GAP), 32'd1);
          in_burst = 1'b1;
          bubbles = 0;
        end
        if (!tx_valid_o) bubbles++;
      end else begin
        if (in_burst) begin
          in_burst = 1'b0;
          have_prev = 1'b1;
          low_run = 0;
          chk("burst_words_left", 32'(exp_q.size()), 32'd0);
          if (exp_bub.size() == 0) chk("unexpected_burst", 32'd1, 32'd0);
          else chk("burst_idle_cycles", 32'(bubbles), 32'(exp_bub.pop_front()));
        end
        low_run++;
      end
    end
  end

  // Drives one packet and pushes its expected lane words. stall_at/stall_len insert
  // pay_valid gaps; rst_at >= 0 pulses reset once that many payload words are in.
  task automatic send_pkt(input bit lng, input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc, input bit fixed, input int stall_at,
                          input int stall_len, input int rst_at, input bit drop_en);
    logic [15:0] wce;
    logic [7:0]  di;
    logic [7:0]  pb[$];
    logic [15:0] words[$];
    int nw, t, sent, stalled, pr_cnt, cr, bound;
    wce = lng ? (wc & 16'hFFFE) : wc;
    nw  = lng ? int'(wce) / 2 : 0;
    di  = {vc, dt};
    for (int i = 0; i < 2 * nw; i++) pb.push_back(fixed ? fixed_bytes[i] : 8'($urandom_range(0, 255)));
    for (int i = 0; i < nw; i++) words.push_back({pb[2*i+1], pb[2*i]});
    exp_q.push_back(16'hB8B8);
    exp_q.push_back({wce[7:0], di});
    exp_q.push_back({ecc_model({wce, di}), wce[15:8]});
    if (lng) begin
      foreach (words[i]) exp_q.push_back(words[i]);
      exp_q.push_back(fixed ? 16'h00F0 : crc_of(pb));
    end
    exp_bub.push_back((nw > 0) ? stall_len : 0);
    if (lng && wc[0]) odd_m = 1'b1;
    if (nw > 0 && stall_len > 0) und_m = 1'b1;

    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_long_i = lng; cmd_vc_i = vc; cmd_dt_i = dt; cmd_wc_i = wc;
    t = 0;
    while (!cmd_ready_o && t < 1000) begin @(negedge clk_i); t++; end
    chk("cmd_accept_in_time", 32'(t < 1000), 32'd1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    if (drop_en) enable_i = 1'b0;

    sent = 0; stalled = 0; pr_cnt = 0; t = 0;
    bound = nw + stall_len + 200;
    while (tx_hs_req_o && t < bound) begin
      if (rst_at >= 0 && sent == rst_at && pay_ready_o) begin
        pay_valid_i = 1'b0;
        reset_i = 1'b1;
        @(negedge clk_i);
        chk("rst_hs_req", 32'(tx_hs_req_o), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid_o), 32'd0);
        chk("rst_tx_data", 32'(tx_data_o), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
        chk("rst_pay_ready", 32'(pay_ready_o), 32'd0);
        chk("rst_err_underrun", 32'(err_underrun_o), 32'd0);
        chk("rst_err_odd_wc", 32'(err_odd_wc_o), 32'd0);
        exp_q.delete();
        exp_bub.delete();
        und_m = 1'b0;
        odd_m = 1'b0;
        @(posedge clk_i);
        #1 reset_i = 1'b0;
        return;
      end
      if (pay_ready_o) pr_cnt++;
      if (pay_ready_o && sent == stall_at && stalled < stall_len) begin
        pay_valid_i = 1'b0;
        stalled++;
      end else if (sent < nw) begin
        pay_valid_i = 1'b1;
        pay_data_i  = words[sent];
        if (pay_ready_o) sent++;
      end else begin
        pay_valid_i = 1'b0;
      end
      @(negedge clk_i);
      t++;
    end
    pay_valid_i = 1'b0;
    chk("burst_end_in_time", 32'(t < bound), 32'd1);
    chk("pay_ready_cycles", 32'(pr_cnt), 32'(nw + ((nw > 0) ? stall_len : 0)));
    chk("payload_words", 32'(sent), 32'(nw));
    chk("err_underrun", 32'(err_underrun_o), 32'(und_m));
    chk("err_odd_wc", 32'(err_odd_wc_o), 32'(odd_m));
    cr = 0;
    for (int i = 0; i < GAP; i++) begin
      if (cmd_ready_o) cr++;
      @(negedge clk_i);
    end
    chk("cmd_ready_in_gap", 32'(cr), 32'd0);
    chk("cmd_ready_after_gap", 32'(cmd_ready_o), 32'(enable_i));
  endtask

  initial begin
    int cr;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] c;
      c = 16'(i);
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      crc_tbl[i] = c;
    end

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("reset_hs_req", 32'(tx_hs_req_o), 32'd0);
    chk("reset_tx_valid", 32'(tx_valid_o), 32'd0);
    chk("reset_tx_data", 32'(tx_data_o), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready_o), 32'd0);
    chk("reset_pay_ready", 32'(pay_ready_o), 32'd0);
    chk("reset_errs", 32'({err_underrun_o, err_odd_wc_o}), 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    @(negedge clk_i);
    chk("cmd_ready_after_reset", 32'(cmd_ready_o), 32'd1);

    send_pkt(1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, -1, 0, -1, 1'b0);   // FS short
    send_pkt(1'b1, 2'd0, 6'h2B, 16'd24,   1'b1, -1, 0, -1, 1'b0);   // CRC vector
    send_pkt(1'b1, 2'd1, 6'h2B, 16'd0,    1'b0, -1, 0, -1, 1'b0);   // empty long
    send_pkt(1'b1, 2'd0, 6'h2B, 16'd24,   1'b1,  5, 3, -1, 1'b0);   // stalled vector
    send_pkt(1'b1, 2'd2, 6'h12, 16'd7,    1'b0, -1, 0, -1, 1'b0);   // odd wc

    // enable dropped mid-burst: burst finishes, nothing new is accepted
    send_pkt(1'b0, 2'd3, 6'h01, 16'h1234, 1'b0, -1, 0, -1, 1'b1);
    cmd_valid_i = 1'b1;
    cr = 0;
    for (int i = 0; i < 30; i++) begin
      if (cmd_ready_o) cr++;
      @(negedge clk_i);
    end
    chk("cmd_ready_while_disabled", 32'(cr), 32'd0);
    cmd_valid_i = 1'b0;
    enable_i = 1'b1;

    send_pkt(1'b1, 2'd0, 6'h2B, 16'd40,   1'b0, -1, 0, 3, 1'b0);    // reset mid-payload
    send_pkt(1'b0, 2'd0, 6'h00, 16'h0000, 1'b0, -1, 0, -1, 1'b0);   // clean FS after reset

    send_pkt(1'b0, 2'd0, 6'h00, 16'h0001, 1'b0, -1, 0, -1, 1'b0);   // FS / RAW10 line / FE
    send_pkt(1'b1, 2'd0, 6'h2B, 16'd640,  1'b0, 100, 2, -1, 1'b0);
    send_pkt(1'b0, 2'd0, 6'h01, 16'h0001, 1'b0, -1, 0, -1, 1'b0);

    for (int k = 0; k < 12; k++) begin
      bit lng;
      logic [15:0] wc;
      int nw, sa, sl;
      lng = 1'($urandom_range(0, 1));
      wc  = lng ? 16'($urandom_range(0, 60)) : 16'($urandom);
      nw  = lng ? int'(wc) / 2 : 0;
      sa  = -1;
      sl  = 0;
      if (nw > 0 && $urandom_range(0, 1) == 1) begin
        sa = $urandom_range(0, nw - 1);
        sl = $urandom_range(1, 4);
      end
      send_pkt(lng, 2'($urandom), 6'($urandom), wc, 1'b0, sa, sl, -1, 1'b0);
    end

    send_pkt(1'b1, 2'd0, 6'h2B, 16'hFFFE, 1'b0, -1, 0, -1, 1'b0);   // longest line

    repeat (4) @(negedge clk_i);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
